// File: rtl/enemy_fire_pkg.sv
// Shared types and constants for the enemy shot scheduler.
package enemy_fire_pkg;

  typedef enum logic [1:0] {
    COOL  = 2'd0,
    PICK  = 2'd1,
    OFFER = 2'd2
  } fire_state_e;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int SHOTS_W = 16;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/rr_first_set.sv
// Rotated priority finder: first set bit of mask_i at or above start_i, wrapping.
module rr_first_set #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] mask_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found_o && mask_i[(int'(start_i) + i) % WIDTH]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'((int'(start_i) + i) % WIDTH);
      end
    end
  end

endmodule

// File: rtl/enemy_fire_sched.sv
// Enemy shot scheduler: cooldown, column/slot pick, valid/ready offer to the bullet pool.
// Define ENEMY_FIRE_RANDOM_EN to seed the column search from an LFSR instead of round-robin.
module enemy_fire_sched
  import enemy_fire_pkg::*;
#(
  parameter int         num_cols_p  = 8,
  parameter int         num_slots_p = 2,
  parameter int         period_p    = 32,
  parameter logic [7:0] lfsr_seed_p = 8'hA5
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          frame_i,
  input  logic                          enable_i,
  input  logic [num_cols_p-1:0]         alive_cols_i,
  input  logic [num_slots_p-1:0]        slot_busy_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [$clog2(num_cols_p)-1:0] col_o,
  output logic [num_slots_p-1:0]        slot_o,
  output logic [SHOTS_W-1:0]            shots_o,
  output logic [1:0]                    state_o
);

  localparam int COL_W   = $clog2(num_cols_p);
  localparam int SLOT_IW = (num_slots_p > 1) ? $clog2(num_slots_p) : 1;
  localparam int CNT_W   = $clog2(period_p + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(period_p - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(num_cols_p - 1);

  localparam logic [1:0] ST_COOL  = COOL;
  localparam logic [1:0] ST_PICK  = PICK;
  localparam logic [1:0] ST_OFFER = OFFER;

  function automatic logic [SHOTS_W-1:0] sat_inc(input logic [SHOTS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cool_q, cool_d;
  logic [COL_W-1:0]       rr_q, rr_d;
  logic [SHOTS_W-1:0]     shots_q, shots_d;
  logic                   valid_q, valid_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [num_slots_p-1:0] slot_q, slot_d;

  logic [COL_W-1:0]       col_start;
  logic                   col_found;
  logic [COL_W-1:0]       col_pick;
  logic                   slot_found;
  logic [SLOT_IW-1:0]     slot_idx;
  logic [num_slots_p-1:0] slot_onehot;

`ifdef ENEMY_FIRE_RANDOM_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = frame_i ? lfsr_step(lfsr_q) : lfsr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) lfsr_q <= lfsr_seed_p;
    else         lfsr_q <= lfsr_d;
  end

  assign col_start = COL_W'(int'(lfsr_q[COL_W-1:0]) % num_cols_p);
`else
  assign col_start = rr_q;
`endif

  rr_first_set #(.WIDTH(num_cols_p), .IDX_W(COL_W)) u_col_find (
    .mask_i  (alive_cols_i),
    .start_i (col_start),
    .found_o (col_found),
    .idx_o   (col_pick)
  );

  // Free slots are the clear busy bits; lowest index wins.
  rr_first_set #(.WIDTH(num_slots_p), .IDX_W(SLOT_IW)) u_slot_find (
    .mask_i  (~slot_busy_i),
    .start_i ('0),
    .found_o (slot_found),
    .idx_o   (slot_idx)
  );

  always_comb begin
    slot_onehot = '0;
    for (int s = 0; s < num_slots_p; s++) begin
      slot_onehot[s] = (SLOT_IW'(s) == slot_idx);
    end
  end

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    rr_d    = rr_q;
    shots_d = shots_q;
    valid_d = valid_q;
    col_d   = col_q;
    slot_d  = slot_q;
    case (state_q)
      ST_COOL: begin
        if (frame_i && enable_i) begin
          if (cool_q == CNT_LAST) state_d = ST_PICK;
          else                    cool_d  = cool_q + 1'b1;
        end
      end
      ST_PICK: begin
        if (!enable_i) begin
          state_d = ST_COOL;
        end else if (!col_found) begin
          state_d = ST_COOL;
          cool_d  = '0;
        end else if (slot_found) begin
          col_d   = col_pick;
          slot_d  = slot_onehot;
          valid_d = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // The offer is held regardless of enable/alive/busy until the pool takes it.
        if (ready_i) begin
          shots_d = sat_inc(shots_q);
          rr_d    = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          cool_d  = '0;
          valid_d = 1'b0;
          slot_d  = '0;
          state_d = ST_COOL;
        end
      end
      default: state_d = ST_COOL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_COOL;
      cool_q  <= '0;
      rr_q    <= '0;
      shots_q <= '0;
      valid_q <= 1'b0;
      col_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      rr_q    <= rr_d;
      shots_q <= shots_d;
      valid_q <= valid_d;
      col_q   <= col_d;
      slot_q  <= slot_d;
    end
  end

  assign valid_o = valid_q;
  assign col_o   = col_q;
  assign slot_o  = slot_q;
  assign shots_o = shots_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_enemy_fire_sched.sv
// Directed bench for enemy_fire_sched with default parameters (8 columns, 2 slots, period 32).
module tb_enemy_fire_sched;

  logic        clk = 1'b0;
  logic        reset_i, frame_i, enable_i, ready_i;
  logic [7:0]  alive_cols_i;
  logic [1:0]  slot_busy_i;
  logic        valid_o;
  logic [2:0]  col_o;
  logic [1:0]  slot_o;
  logic [15:0] shots_o;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;

  enemy_fire_sched dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .frame_i      (frame_i),
    .enable_i     (enable_i),
    .alive_cols_i (alive_cols_i),
    .slot_busy_i  (slot_busy_i),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .col_o        (col_o),
    .slot_o       (slot_o),
    .shots_o      (shots_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] alive;
    logic [1:0] busy;
    logic [2:0] col;
    logic [1:0] slot;
  } shot_vec_t;

  shot_vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      tick();
    end
  endtask

  // 31 frames leave the counter one short; the 32nd moves to PICK.
  task automatic run_to_pick();
    frames(31);
    chk("cool_not_expired_state", {30'd0, state_o}, 32'd0);
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
    chk("pick_state_no_valid", {29'd0, valid_o, state_o}, {29'd0, 1'b0, 2'd1});
  endtask

  function automatic logic [31:0] offer_word(input logic v, input logic [2:0] c, input logic [1:0] s);
    return {26'd0, v, c, s};
  endfunction

  initial begin
    vecs[0]  = '{8'hFF, 2'b00, 3'd0, 2'b01};
    vecs[1]  = '{8'hFF, 2'b01, 3'd1, 2'b10};
    vecs[2]  = '{8'hFF, 2'b10, 3'd2, 2'b01};
    vecs[3]  = '{8'hFF, 2'b00, 3'd3, 2'b01};
    vecs[4]  = '{8'hFF, 2'b00, 3'd4, 2'b01};
    vecs[5]  = '{8'hFF, 2'b00, 3'd5, 2'b01};
    vecs[6]  = '{8'hFF, 2'b00, 3'd6, 2'b01};
    vecs[7]  = '{8'hFF, 2'b00, 3'd7, 2'b01};
    vecs[8]  = '{8'hFF, 2'b00, 3'd0, 2'b01};
    vecs[9]  = '{8'hFF, 2'b00, 3'd1, 2'b01};
    vecs[10] = '{8'hFF, 2'b00, 3'd2, 2'b01};
    vecs[11] = '{8'h84, 2'b00, 3'd7, 2'b01};
    vecs[12] = '{8'h84, 2'b00, 3'd2, 2'b01};

    reset_i = 1'b1; frame_i = 1'b0; enable_i = 1'b0; ready_i = 1'b0;
    alive_cols_i = 8'h00; slot_busy_i = 2'b00;
    tick(); tick();
    reset_i = 1'b0;
    tick();
    chk("reset_offer", offer_word(valid_o, col_o, slot_o), 32'd0);
    chk("reset_shots", {16'd0, shots_o}, 32'd0);
    chk("reset_state", {30'd0, state_o}, 32'd0);

    enable_i = 1'b1;
    ready_i  = 1'b1;
    for (int v = 0; v < 13; v++) begin
      alive_cols_i = vecs[v].alive;
      slot_busy_i  = vecs[v].busy;
      run_to_pick();
      tick();
      chk($sformatf("vec%0d_offer", v), offer_word(valid_o, col_o, slot_o),
          offer_word(1'b1, vecs[v].col, vecs[v].slot));
      tick();
      chk($sformatf("vec%0d_shots", v), {16'd0, shots_o}, v + 1);
      chk($sformatf("vec%0d_done", v), offer_word(valid_o, 3'd0, slot_o), 32'd0);
    end

    // All slots busy at expiry: wait in PICK, then launch when slot 0 frees.
    alive_cols_i = 8'hFF;
    slot_busy_i  = 2'b11;
    ready_i      = 1'b0;
    run_to_pick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busy_wait_pick", {29'd0, valid_o, state_o}, {29'd0, 1'b0, 2'd1});
    end
    slot_busy_i = 2'b10;
    tick();
    chk("busy_release_offer", offer_word(valid_o, col_o, slot_o), offer_word(1'b1, 3'd3, 2'b01));

    // Stalled offer must hold while enable, alive and busy move.
    for (int k = 0; k < 10; k++) begin
      if (k == 2) enable_i = 1'b0;
      alive_cols_i = 8'h01 << (k % 8);
      slot_busy_i  = 2'(k);
      tick();
      chk("stall_hold", offer_word(valid_o, col_o, slot_o), offer_word(1'b1, 3'd3, 2'b01));
    end
    ready_i = 1'b1; enable_i = 1'b1; alive_cols_i = 8'hFF; slot_busy_i = 2'b00;
    tick();
    chk("stall_accept_shots", {16'd0, shots_o}, 32'd14);
    chk("stall_accept_idle", {29'd0, valid_o, state_o}, 32'd0);

    // Reset while an offer is pending.
    ready_i = 1'b0;
    run_to_pick();
    tick();
    chk("pre_reset_offer", offer_word(valid_o, col_o, slot_o), offer_word(1'b1, 3'd4, 2'b01));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("reset_in_offer", offer_word(valid_o, col_o, slot_o), 32'd0);
    chk("reset_in_offer_shots", {16'd0, shots_o}, 32'd0);
    chk("reset_in_offer_state", {30'd0, state_o}, 32'd0);

    // No alive column at expiry: back to COOL with a fresh count.
    ready_i = 1'b1;
    alive_cols_i = 8'h00;
    run_to_pick();
    tick();
    chk("no_alive_cool", {29'd0, valid_o, state_o}, 32'd0);
    alive_cols_i = 8'hFF;
    run_to_pick();
    tick();
    chk("after_restart_offer", offer_word(valid_o, col_o, slot_o), offer_word(1'b1, 3'd0, 2'b01));
    tick();
    chk("after_restart_shots", {16'd0, shots_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
